// File: rtl/apb_request_master.sv
// Single-outstanding APB requester: turns valid/ready register commands into APB
// SETUP/ACCESS transfers and returns read data and status on a valid/ready response channel.
module apb_request_master #(
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  // Request channel
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_write,
  input  logic [ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [2:0]               i_req_prot,
  input  logic [BUS_WIDTH-1:0]     i_req_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_req_strobe,
  // Response channel
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic [1:0]               o_rsp_status,
  // APB requester port
  output logic                     o_psel,
  output logic                     o_penable,
  output logic                     o_pwrite,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic [BUS_WIDTH-1:0]     o_pwdata,
  output logic [BUS_WIDTH/8-1:0]   o_pstrb,
  input  logic                     i_pready,
  input  logic                     i_pslverr,
  input  logic [BUS_WIDTH-1:0]     i_prdata
);

  localparam int unsigned StrbWidth = BUS_WIDTH / 8;
  localparam int unsigned CntWidth  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusTimeout = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResponse
  } state_e;

  state_e r_state, w_state_next;

  logic [CntWidth-1:0]      r_count, w_count_next, w_count_inc;
  logic                     w_timeout;

  logic                     r_psel, w_psel_next;
  logic                     r_penable, w_penable_next;
  logic                     r_pwrite, w_pwrite_next;
  logic [ADDRESS_WIDTH-1:0] r_paddr, w_paddr_next;
  logic [2:0]               r_pprot, w_pprot_next;
  logic [BUS_WIDTH-1:0]     r_pwdata, w_pwdata_next;
  logic [StrbWidth-1:0]     r_pstrb, w_pstrb_next;
  logic                     r_rsp_valid, w_rsp_valid_next;
  logic [BUS_WIDTH-1:0]     r_rsp_read_data, w_rsp_read_data_next;
  logic [1:0]               r_rsp_status, w_rsp_status_next;

  // The counter only ever reaches TIMEOUT_CYCLES because ACCESS is left on that cycle.
  assign w_count_inc = r_count + CntWidth'(1);
  assign w_timeout   = (TIMEOUT_CYCLES > 0) && (w_count_inc == CntWidth'(TIMEOUT_CYCLES));

  always_comb begin
    w_state_next         = r_state;
    w_count_next         = r_count;
    w_psel_next          = r_psel;
    w_penable_next       = r_penable;
    w_pwrite_next        = r_pwrite;
    w_paddr_next         = r_paddr;
    w_pprot_next         = r_pprot;
    w_pwdata_next        = r_pwdata;
    w_pstrb_next         = r_pstrb;
    w_rsp_valid_next     = r_rsp_valid;
    w_rsp_read_data_next = r_rsp_read_data;
    w_rsp_status_next    = r_rsp_status;

    case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_state_next   = StSetup;
          w_count_next   = '0;
          w_psel_next    = 1'b1;
          w_penable_next = 1'b0;
          w_pwrite_next  = i_req_write;
          w_paddr_next   = i_req_address;
          w_pprot_next   = i_req_prot;
          w_pwdata_next  = i_req_write_data;
          w_pstrb_next   = i_req_write ? i_req_strobe : '0;
        end
      end

      StSetup: begin
        w_state_next   = StAccess;
        w_penable_next = 1'b1;
      end

      StAccess: begin
        // PREADY wins over a timeout landing in the same cycle.
        if (i_pready) begin
          w_state_next         = StResponse;
          w_psel_next          = 1'b0;
          w_penable_next       = 1'b0;
          w_rsp_valid_next     = 1'b1;
          w_rsp_read_data_next = r_pwrite ? '0 : i_prdata;
          w_rsp_status_next    = {i_pslverr, 1'b0};
        end else if (w_timeout) begin
          w_state_next         = StResponse;
          w_count_next         = w_count_inc;
          w_psel_next          = 1'b0;
          w_penable_next       = 1'b0;
          w_rsp_valid_next     = 1'b1;
          w_rsp_read_data_next = '0;
          w_rsp_status_next    = StatusTimeout;
        end else if (TIMEOUT_CYCLES > 0) begin
          w_count_next = w_count_inc;
        end
      end

      StResponse: begin
        if (i_rsp_ready) begin
          w_state_next     = StIdle;
          w_rsp_valid_next = 1'b0;
        end
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= StIdle;
      r_count         <= '0;
      r_psel          <= 1'b0;
      r_penable       <= 1'b0;
      r_pwrite        <= 1'b0;
      r_paddr         <= '0;
      r_pprot         <= '0;
      r_pwdata        <= '0;
      r_pstrb         <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_read_data <= '0;
      r_rsp_status    <= StatusOk;
    end else begin
      r_state         <= w_state_next;
      r_count         <= w_count_next;
      r_psel          <= w_psel_next;
      r_penable       <= w_penable_next;
      r_pwrite        <= w_pwrite_next;
      r_paddr         <= w_paddr_next;
      r_pprot         <= w_pprot_next;
      r_pwdata        <= w_pwdata_next;
      r_pstrb         <= w_pstrb_next;
      r_rsp_valid     <= w_rsp_valid_next;
      r_rsp_read_data <= w_rsp_read_data_next;
      r_rsp_status    <= w_rsp_status_next;
    end
  end

  assign o_req_ready     = (r_state == StIdle);
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_read_data = r_rsp_read_data;
  assign o_rsp_status    = r_rsp_status;
  assign o_psel          = r_psel;
  assign o_penable       = r_penable;
  assign o_pwrite        = r_pwrite;
  assign o_paddr         = r_paddr;
  assign o_pprot         = r_pprot;
  assign o_pwdata        = r_pwdata;
  assign o_pstrb         = r_pstrb;

endmodule

// File: tb/tb_apb_request_master.sv
// Self-checking bench for apb_request_master: directed table, random transfers against a
// transaction-level latency/status model, and hand-written hold and reset sequences.
module tb_apb_request_master;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;
  localparam int TO = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_req_valid, o_req_ready, i_req_write;
  logic [AW-1:0] i_req_address;
  logic [2:0]    i_req_prot;
  logic [BW-1:0] i_req_write_data;
  logic [SW-1:0] i_req_strobe;
  logic          o_rsp_valid, i_rsp_ready;
  logic [BW-1:0] o_rsp_read_data;
  logic [1:0]    o_rsp_status;
  logic          o_psel, o_penable, o_pwrite;
  logic [AW-1:0] o_paddr;
  logic [2:0]    o_pprot;
  logic [BW-1:0] o_pwdata;
  logic [SW-1:0] o_pstrb;
  logic          i_pready, i_pslverr;
  logic [BW-1:0] i_prdata;

  always #5 i_clk = ~i_clk;

  apb_request_master #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_write     (i_req_write),
    .i_req_address   (i_req_address),
    .i_req_prot      (i_req_prot),
    .i_req_write_data(i_req_write_data),
    .i_req_strobe    (i_req_strobe),
    .o_rsp_valid     (o_rsp_valid),
    .i_rsp_ready     (i_rsp_ready),
    .o_rsp_read_data (o_rsp_read_data),
    .o_rsp_status    (o_rsp_status),
    .o_psel          (o_psel),
    .o_penable       (o_penable),
    .o_pwrite        (o_pwrite),
    .o_paddr         (o_paddr),
    .o_pprot         (o_pprot),
    .o_pwdata        (o_pwdata),
    .o_pstrb         (o_pstrb),
    .i_pready        (i_pready),
    .i_pslverr       (i_pslverr),
    .i_prdata        (i_prdata)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    logic [BW-1:0] wdata;
    logic [SW-1:0] strb;
    int            waits;   // ACCESS cycles with PREADY low before it goes high
    logic          err;
    logic [BW-1:0] prdata;
    int            hold;    // cycles the response is left unconsumed
    int            exp_lat;
    logic [1:0]    exp_st;
    logic [BW-1:0] exp_rd;
  } txn_t;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: a wait longer than the watchdog turns into a timeout.
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    if (t.waits >= TO) begin
      r.exp_lat = 2 + TO;
      r.exp_st  = 2'b11;
      r.exp_rd  = '0;
    end else begin
      r.exp_lat = 3 + t.waits;
      r.exp_st  = {t.err, 1'b0};
      r.exp_rd  = t.wr ? '0 : t.prdata;
    end
    return r;
  endfunction

  task automatic run_txn(input txn_t t, input string name);
    int  lat;
    int  acc;
    bit  done;
    logic [BW-1:0] rd_seen;
    logic [1:0]    st_seen;
    chk({name, ".req_ready_idle"}, o_req_ready, 1);
    i_req_valid      = 1'b1;
    i_req_write      = t.wr;
    i_req_address    = t.addr;
    i_req_prot       = t.prot;
    i_req_write_data = t.wdata;
    i_req_strobe     = t.strb;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid      = 1'b0;
    i_req_address    = ~t.addr;
    i_req_write_data = ~t.wdata;
    lat  = 1;
    acc  = 0;
    done = 1'b0;
    chk({name, ".setup_psel"}, {o_psel, o_penable, o_req_ready}, 3'b100);
    while (!done && lat < 40) begin
      if (o_rsp_valid) begin
        done = 1'b1;
      end else begin
        if (lat == 2) chk({name, ".access_penable"}, {o_psel, o_penable}, 2'b11);
        if (o_psel && o_penable) begin
          acc++;
          i_pready  = (acc > t.waits);
          i_pslverr = t.err;
          i_prdata  = t.prdata;
        end else begin
          // SETUP must ignore these.
          i_pready  = 1'b1;
          i_pslverr = 1'b1;
          i_prdata  = '1;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        lat++;
      end
    end
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    chk({name, ".latency"}, done ? lat : -1, t.exp_lat);
    chk({name, ".status"}, o_rsp_status, t.exp_st);
    chk({name, ".rdata"}, o_rsp_read_data, t.exp_rd);
    chk({name, ".apb_idle"}, {o_psel, o_penable, o_req_ready}, 3'b000);
    chk({name, ".paddr"}, o_paddr, t.addr);
    chk({name, ".pctl"}, {o_pwrite, o_pprot}, {t.wr, t.prot});
    chk({name, ".pwdata"}, o_pwdata, t.wdata);
    chk({name, ".pstrb"}, o_pstrb, t.wr ? t.strb : '0);
    rd_seen = o_rsp_read_data;
    st_seen = o_rsp_status;
    for (int k = 0; k < t.hold; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      chk({name, ".hold"}, {o_rsp_valid, o_req_ready, o_rsp_status, o_rsp_read_data},
          {1'b1, 1'b0, st_seen, rd_seen});
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    chk({name, ".handshake"}, {o_rsp_valid, o_req_ready}, 2'b01);
    chk({name, ".paddr_kept"}, o_paddr, t.addr);
  endtask

  txn_t vecs[7];
  txn_t t;

  initial begin
    //        wr    addr   prot  wdata         strb  wt err prdata        hold lat st     rd
    vecs[0] = '{1'b1, 8'h10, 3'd0, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        5, 3, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 8'h04, 3'd2, 32'h0,        4'hF, 2, 0, 32'h12345678, 0, 5, 2'b00, 32'h12345678};
    vecs[2] = '{1'b0, 8'h08, 3'd1, 32'h0,        4'h0, 0, 1, 32'hCAFEF00D, 1, 3, 2'b10, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 8'h0C, 3'd7, 32'h55,       4'h3, 9, 0, 32'h11111111, 0, 6, 2'b11, 32'h0};
    vecs[4] = '{1'b0, 8'h20, 3'd4, 32'h0,        4'h0, 3, 0, 32'hA5A5A5A5, 0, 6, 2'b00, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 8'hFF, 3'd3, 32'h01020304, 4'h5, 1, 1, 32'h99999999, 2, 4, 2'b10, 32'h0};
    vecs[6] = '{1'b1, 8'h30, 3'd5, 32'hFFFF0000, 4'hC, 4, 1, 32'h77777777, 0, 6, 2'b11, 32'h0};

    i_rst_n = 1'b0;
    i_req_valid = 1'b0;
    i_req_write = 1'b0;
    i_req_address = '0;
    i_req_prot = '0;
    i_req_write_data = '0;
    i_req_strobe = '0;
    i_rsp_ready = 1'b0;
    i_pready = 1'b0;
    i_pslverr = 1'b0;
    i_prdata = '0;
    #12;
    chk("reset.ctl", {o_req_ready, o_psel, o_penable, o_pwrite, o_rsp_valid}, 5'b10000);
    chk("reset.data", {o_paddr, o_pprot, o_pwdata, o_pstrb, o_rsp_read_data, o_rsp_status}, '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of ACCESS drops the command without a response.
    i_req_valid = 1'b1;
    i_req_write = 1'b1;
    i_req_address = 8'h44;
    i_req_write_data = 32'h0BADF00D;
    i_req_strobe = 4'hF;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_mid.in_access", {o_psel, o_penable}, 2'b11);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_mid.async", {o_psel, o_penable, o_rsp_valid, o_req_ready}, 4'b0001);
    chk("rst_mid.regs", {o_paddr, o_pwdata, o_pstrb}, '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_pready = 1'b1;
    repeat (3) @(negedge i_clk);
    i_pready = 1'b0;
    chk("rst_mid.no_rsp", {o_rsp_valid, o_psel, o_req_ready}, 3'b001);
    run_txn(model('{1'b0, 8'h48, 3'd0, 32'h0, 4'h0, 1, 0, 32'h600DCAFE, 0, 0, 2'b00, 32'h0}),
            "after_rst");

    for (int i = 0; i < 40; i++) begin
      t.wr     = 1'($urandom_range(0, 1));
      t.addr   = AW'($urandom);
      t.prot   = 3'($urandom);
      t.wdata  = $urandom;
      t.strb   = SW'($urandom);
      t.waits  = int'($urandom_range(0, 6));
      t.err    = 1'($urandom_range(0, 1));
      t.prdata = $urandom;
      t.hold   = int'($urandom_range(0, 2));
      run_txn(model(t), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
